// File: rtl/dec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dec_ctrl_pkg
// Shared constants and types for the serial (7,4) decoder feed controller:
// code geometry, queue depths, the all-zero filler codeword, tag encodings
// and the sequencer state type.
// -----------------------------------------------------------------------------
package dec_ctrl_pkg;

  localparam int N          = 7;  // codeword length, bits serialized per word
  localparam int K          = 4;  // decoded message bits per word
  localparam int FIFO_DEPTH = 4;  // input codeword FIFO entries (power of 2)
  localparam int TAG_DEPTH  = 4;  // words in flight inside the decoder (power of 2)

  localparam logic [N-1:0] FILL_CW = 7'b0;

  // Tag carried alongside each word through the decoder.
  localparam logic TAG_USER = 1'b1;
  localparam logic TAG_FILL = 1'b0;

  typedef enum logic [1:0] {
    RESET_HOLD,
    LOAD,
    SHIFT
  } state_t;

endpackage

// File: rtl/cw_fifo.sv
// -----------------------------------------------------------------------------
// cw_fifo
// Synchronous show-ahead FIFO for upstream codewords.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write request (honoured when not full, or when full and a
//               read happens in the same cycle)
//   wr_data   : word to store
//   rd_en     : read request (ignored when empty; no write-to-read bypass)
//   rd_data   : current head entry, valid whenever empty is low
//   count     : number of stored entries
//   full      : count == DEPTH
//   empty     : count == 0
// -----------------------------------------------------------------------------
module cw_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count and pointers alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_feed_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_feed_ctrl
// Sequencer feeding a serial (7,4) block decoder. Codewords are queued in a
// FIFO, serialized LSB-first as the decoder pulls bits (dec_in_flag), and
// all-zero filler words keep the stream continuous when the FIFO runs dry.
// Each word start pushes a USER/FILL tag; the tag is popped when the decoder
// has returned K bits, and only USER words produce an out_valid pulse.
//   clk, rst     : clock, asynchronous active-high reset
//   cw_valid/cw_data/cw_ready : upstream codeword handshake
//   dec_rst_n    : decoder reset, released one clock after rst falls
//   dec_data_in  : serial bit to decoder, dec_in_flag consumes it
//   dec_data_out/dec_out_flag : decoded serial bits from decoder
//   out_valid/out_data : one-cycle pulse with an assembled K-bit user word
//   busy         : FIFO holds words or a user word is still in flight
//   tag_ovf      : sticky, a word started while the tag queue was full
// -----------------------------------------------------------------------------
module decoder_feed_ctrl
  import dec_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cw_valid,
  input  logic [N-1:0] cw_data,
  output logic         cw_ready,
  output logic         dec_rst_n,
  output logic         dec_data_in,
  input  logic         dec_in_flag,
  input  logic         dec_data_out,
  input  logic         dec_out_flag,
  output logic         out_valid,
  output logic [K-1:0] out_data,
  output logic         busy,
  output logic         tag_ovf
);

  localparam int BW = $clog2(N);
  localparam int RW = $clog2(K);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(N-1);
  localparam logic [RW-1:0] LAST_RCV = RW'(K-1);
  localparam logic [TW:0]   TAG_FULL = (TW+1)'(TAG_DEPTH);

  state_t state, state_nxt;

  logic [N-1:0]  shreg;
  logic [BW-1:0] bit_cnt;
  logic          word_start;
  logic          start_tag;

  logic                          fifo_wr;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [N-1:0]                  fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  logic          tq_mem [TAG_DEPTH];
  logic [TW-1:0] tq_wr_ptr;
  logic [TW-1:0] tq_rd_ptr;
  logic [TW:0]   tq_count;
  logic [TW:0]   user_cnt;
  logic          tq_push;
  logic          tq_pop;
  logic          pop_tag;
  logic          word_done;
  logic          user_in;
  logic          user_out;

  logic [K-1:0]  asm_reg;
  logic [K-1:0]  asm_nxt;
  logic [RW-1:0] rcv_cnt;

  // ---------------------------------------------------------------- input side
  assign cw_ready = ~rst & ~fifo_full;
  assign fifo_wr  = cw_valid & cw_ready;

  // A word starts in LOAD, or on the consuming edge of the last bit so that
  // consecutive words leave no bubble on dec_data_in.
  assign word_start = (state == LOAD) |
                      ((state == SHIFT) & dec_in_flag & (bit_cnt == LAST_BIT));
  assign start_tag  = fifo_empty ? TAG_FILL : TAG_USER;

  cw_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_cw_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (cw_data),
    .rd_en   (word_start),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_rst_n <= 1'b0;
    else     dec_rst_n <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      RESET_HOLD: state_nxt = LOAD;
      LOAD:       state_nxt = SHIFT;
      SHIFT:      state_nxt = SHIFT;
      default:    state_nxt = RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (word_start) begin
      shreg   <= fifo_empty ? FILL_CW : fifo_rd_data;
      bit_cnt <= '0;
    end else if ((state == SHIFT) && dec_in_flag) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign dec_data_in = (state == SHIFT) & shreg[0];

  // ----------------------------------------------------------------- tag queue
  assign word_done = dec_out_flag & (rcv_cnt == LAST_RCV);
  assign tq_pop    = word_done & (tq_count != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign tq_push   = word_start & ((tq_count != TAG_FULL) | tq_pop);
  assign pop_tag   = tq_pop ? tq_mem[tq_rd_ptr] : TAG_FILL;
  assign user_in   = tq_push & (start_tag == TAG_USER);
  assign user_out  = tq_pop & (pop_tag == TAG_USER);

  always_ff @(posedge clk) begin
    if (tq_push) tq_mem[tq_wr_ptr] <= start_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tq_wr_ptr <= '0;
      tq_rd_ptr <= '0;
      tq_count  <= '0;
      user_cnt  <= '0;
      tag_ovf   <= 1'b0;
    end else begin
      if (tq_push) tq_wr_ptr <= tq_wr_ptr + 1'b1;
      if (tq_pop)  tq_rd_ptr <= tq_rd_ptr + 1'b1;
      case ({tq_push, tq_pop})
        2'b10:   tq_count <= tq_count + 1'b1;
        2'b01:   tq_count <= tq_count - 1'b1;
        default: tq_count <= tq_count;
      endcase
      user_cnt <= user_cnt + {{TW{1'b0}}, user_in} - {{TW{1'b0}}, user_out};
      if (word_start && !tq_push) tag_ovf <= 1'b1;
    end
  end

  assign busy = (fifo_count != '0) | (user_cnt != '0);

  // --------------------------------------------------------------- output side
  // First received decoded bit ends up in bit 0.
  assign asm_nxt = {dec_data_out, asm_reg[K-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg   <= '0;
      rcv_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (dec_out_flag) begin
        asm_reg <= asm_nxt;
        rcv_cnt <= word_done ? '0 : rcv_cnt + 1'b1;
        if (word_done && (pop_tag == TAG_USER)) begin
          out_valid <= 1'b1;
          out_data  <= asm_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decoder_feed_ctrl
// Drives decoder_feed_ctrl with a behavioural serial (7,4) Hamming decoder
// that pulls bits and returns decoded bits at random rates. Accepted
// codewords push the expected nibble (golden decode) and the expected serial
// codeword into queues; independent monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_decoder_feed_ctrl;
  import dec_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cw_valid = 1'b0;
  logic [N-1:0] cw_data = '0;
  logic         cw_ready;
  logic         dec_rst_n;
  logic         dec_data_in;
  logic         dec_in_flag = 1'b0;
  logic         dec_data_out = 1'b0;
  logic         dec_out_flag = 1'b0;
  logic         out_valid;
  logic [K-1:0] out_data;
  logic         busy;
  logic         tag_ovf;

  always #5 clk = ~clk;

  decoder_feed_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cw_valid     (cw_valid),
    .cw_data      (cw_data),
    .cw_ready     (cw_ready),
    .dec_rst_n    (dec_rst_n),
    .dec_data_in  (dec_data_in),
    .dec_in_flag  (dec_in_flag),
    .dec_data_out (dec_data_out),
    .dec_out_flag (dec_out_flag),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .tag_ovf      (tag_ovf)
  );

  int           total = 0;
  int           bad   = 0;
  logic [K-1:0] exp_q[$];   // expected decoded user words, acceptance order
  logic [N-1:0] ser_q[$];   // expected user codewords on the serial side
  int           n_out = 0;
  bit           stall = 1'b0;
  bit           dense = 1'b0;

  logic [N-1:0] rx_cw;
  int           rx_cnt = 0;
  logic         obit_q[$];
  int           alive = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Hamming (7,4): bit i of the codeword is position i+1; parity at 1,2,4.
  function automatic logic [K-1:0] golden_decode(input logic [N-1:0] cw);
    logic [N-1:0] c;
    int syn;
    c   = cw;
    syn = 0;
    for (int i = 0; i < N; i++) if (c[i]) syn ^= (i + 1);
    if (syn != 0) c[syn-1] = ~c[syn-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Received serial codeword: user words must arrive in acceptance order;
  // any other word must be an all-zero filler.
  task automatic serial_check(input logic [N-1:0] cw);
    if (ser_q.size() > 0 && cw == ser_q[0]) begin
      check("serial_cw", cw, ser_q[0]);
      void'(ser_q.pop_front());
    end else if (cw != FILL_CW) begin
      check("serial_cw", cw, (ser_q.size() > 0) ? ser_q[0] : FILL_CW);
    end
  endtask

  // Behavioural decoder: pulls bits, decodes whole words, returns K bits.
  always @(negedge clk) begin
    if (!dec_rst_n) begin
      dec_in_flag  = 1'b0;
      dec_out_flag = 1'b0;
      dec_data_out = 1'b0;
      rx_cnt       = 0;
      alive        = 0;
      obit_q.delete();
    end else begin
      logic [K-1:0] d;
      if (alive < 2) alive++;
      if (obit_q.size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
        dec_out_flag = 1'b1;
        dec_data_out = obit_q.pop_front();
      end else begin
        dec_out_flag = 1'b0;
        dec_data_out = 1'($urandom);
      end
      dec_in_flag = (alive >= 2) && !stall && (dense || $urandom_range(0, 3) != 0);
      if (dec_in_flag) begin
        rx_cw[rx_cnt] = dec_data_in;
        rx_cnt++;
        if (rx_cnt == N) begin
          rx_cnt = 0;
          serial_check(rx_cw);
          d = golden_decode(rx_cw);
          for (int i = 0; i < K; i++) obit_q.push_back(d[i]);
        end
      end
    end
  end

  // Scoreboard producer (acceptances) and consumer (out_valid pulses).
  always @(negedge clk) begin
    if (!rst && cw_valid && cw_ready) begin
      exp_q.push_back(golden_decode(cw_data));
      ser_q.push_back(cw_data);
    end
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) check("out_unexpected", out_valid, 1'b0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time %0t, want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [N-1:0] cw);
    int waited;
    waited   = 0;
    cw_valid = 1'b1;
    cw_data  = cw;
    forever begin
      @(negedge clk);
      if (cw_ready) break;
      waited++;
      if (waited > 300) begin
        check("push_timeout", cw_ready, 1'b1);
        break;
      end
    end
    tick(1);
    cw_valid = 1'b0;
    cw_data  = N'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    cw_valid = 1'b0;
    exp_q.delete();
    ser_q.delete();
    @(negedge clk);
    check("rst_cw_ready", cw_ready, 1'b0);
    check("rst_dec_rst_n", dec_rst_n, 1'b0);
    check("rst_dec_data_in", dec_data_in, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tag_ovf", tag_ovf, 1'b0);
    tick(cycles);
    rst = 1'b0;
    @(negedge clk);
    check("dec_rst_n_hold", dec_rst_n, 1'b0);
    check("ready_after_rst", cw_ready, 1'b1);
    @(negedge clk);
    check("dec_rst_n_rise", dec_rst_n, 1'b1);
    tick(1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 3000) begin
      tick(1);
      w++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [N-1:0] stream [6];
    logic         held;
    int           n0;
    int           w;
    stream = '{7'b1010011, 7'b0000111, 7'b1110010, 7'b0011110, 7'b0000101, 7'b0000000};

    tick(1);
    do_reset(3);

    // Mid-word reset: words in flight are abandoned without output.
    push_word(7'b1101001);
    push_word(7'b0110110);
    tick(12);
    do_reset(3);

    // Back-to-back stream.
    n0 = n_out;
    foreach (stream[i]) push_word(stream[i]);
    drain();
    check("stream_pulses", n_out - n0, 6);
    check("stream_last_zero", out_data, 4'h0);

    // Stall on bit 3: dec_data_in must hold.
    push_word(7'b1100110);
    push_word(7'b0101101);
    w = 0;
    while (rx_cnt != 3 && w < 200) begin
      tick(1);
      w++;
    end
    stall = 1'b1;
    @(negedge clk);
    #1;
    held = dec_data_in;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_hold", dec_data_in, held);
    end
    tick(1);
    stall = 1'b0;
    drain();

    // Starvation: one word, then fillers only.
    dense = 1'b1;
    n0 = n_out;
    push_word(7'b0110011);
    tick(40);
    check("starve_pulses", n_out - n0, 1);
    check("starve_busy", busy, 1'b0);
    dense = 1'b0;

    // Full FIFO with the decoder not pulling bits.
    stall = 1'b1;
    tick(2);
    n0 = n_out;
    for (int i = 0; i < FIFO_DEPTH; i++) push_word(N'($urandom));
    @(negedge clk);
    check("full_ready", cw_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    tick(1);
    fork
      begin
        push_word(7'b1001100);
        push_word(7'b0111011);
      end
      begin
        tick(10);
        stall = 1'b0;
      end
    join
    drain();
    check("full_pulses", n_out - n0, 6);

    // Keep the FIFO full while words leave: pushes coincide with pops.
    n0 = n_out;
    for (int i = 0; i < 10; i++) push_word(N'($urandom));
    drain();
    check("fullflow_pulses", n_out - n0, 10);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      push_word(N'($urandom));
      tick($urandom_range(0, 3));
    end
    drain();

    check("final_tag_ovf", tag_ovf, 1'b0);
    check("final_serial_left", ser_q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
